// File: rtl/hb_decim2_if.sv
// Stream interface of hb_decim2: the free-running filter input and the valid/ready output.
// The slave modport is the decimator's view; the master modport is the surrounding system's view.
interface hb_decim2_if #(
   parameter int DW = 16
);
   logic          in_valid;
   logic [DW-1:0] x_in;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] y_out;

   modport master (
      output in_valid,
      output x_in,
      output out_ready,
      input  out_valid,
      input  y_out
   );

   modport slave (
      input  in_valid,
      input  x_in,
      input  out_ready,
      output out_valid,
      output y_out
   );
endinterface

// File: rtl/hb_decim2.sv
// Decimate-by-2 stage behind hb_filter: keeps one input phase and queues it in a small FWFT FIFO.
// Define HB_DECIM_OVF_EN to add the sticky overflow flag and the saturating drop counter.
module hb_decim2 #(
   parameter int DW    = 16,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   hb_decim2_if.slave             bus,
   input  logic                   phase_sel,
   output logic [$clog2(DEPTH):0] fill
`ifdef HB_DECIM_OVF_EN
   ,
   output logic                   overflow,
   output logic [15:0]            drop_cnt
`endif
);

   localparam int          AW   = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic          ph_q, ph_d;
   logic [AW-1:0] wrPtr_q, wrPtr_d;
   logic [AW-1:0] rdPtr_q, rdPtr_d;
   logic [AW:0]   fill_q, fill_d;
   logic [DW-1:0] mem_q [DEPTH];

   logic keep;
   logic rd;
   logic wr;

   // A full FIFO still accepts a kept sample when the head leaves in the same cycle.
   always_comb begin
      keep    = bus.in_valid && (ph_q == phase_sel);
      rd      = (fill_q != '0) && bus.out_ready;
      wr      = keep && ((fill_q != FULL) || rd);
      ph_d    = ph_q ^ bus.in_valid;
      wrPtr_d = wr ? wrPtr_q + 1'b1 : wrPtr_q;
      rdPtr_d = rd ? rdPtr_q + 1'b1 : rdPtr_q;
      fill_d  = fill_q;
      if (wr && !rd) begin
         fill_d = fill_q + 1'b1;
      end else if (rd && !wr) begin
         fill_d = fill_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ph_q    <= 1'b0;
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         fill_q  <= '0;
      end else begin
         ph_q    <= ph_d;
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         fill_q  <= fill_d;
      end
   end

   // Storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (wr) begin
         mem_q[wrPtr_q] <= bus.x_in;
      end
   end

   assign bus.out_valid = (fill_q != '0);
   assign bus.y_out     = (fill_q != '0) ? mem_q[rdPtr_q] : '0;
   assign fill          = fill_q;

`ifdef HB_DECIM_OVF_EN
   logic        drop;
   logic        overflow_q;
   logic [15:0] dropCnt_q, dropCnt_d;

   always_comb begin
      drop      = keep && (fill_q == FULL) && !rd;
      dropCnt_d = dropCnt_q;
      if (drop && (dropCnt_q != 16'hFFFF)) begin
         dropCnt_d = dropCnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         overflow_q <= 1'b0;
         dropCnt_q  <= '0;
      end else begin
         overflow_q <= overflow_q | drop;
         dropCnt_q  <= dropCnt_d;
      end
   end

   assign overflow = overflow_q;
   assign drop_cnt = dropCnt_q;
`endif

endmodule

// File: doc/hb_decim2.md
# hb_decim2

Decimate-by-2 output stage sitting directly downstream of `hb_filter`. It consumes the filter's free-running 16-bit signed output stream, keeps every second sample (selectable phase) and buffers kept samples in a small first-word-fall-through FIFO with a valid/ready interface toward the next consumer. The upstream filter has no backpressure, so samples that arrive while the FIFO is full are dropped and accounted for.

## Interface
- `DW`, 16: sample width, two's complement.
- `DEPTH`, 4: FIFO depth in samples; power of 2, ≥ 2.
- `clk`  in  1: single clock; all logic rising-edge.
- `reset`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: `x_in` carries a new filter output this cycle.
- `x_in`  in  DW: signed sample from `hb_filter.y_out`.
- `phase_sel`  in  1: which input phase is kept (0 = 1st, 3rd, …; 1 = 2nd, 4th, …); quasi-static.
- `out_valid`  out  1: FIFO head is valid.
- `out_ready`  in  1: consumer accepts head this cycle.
- `y_out`  out  DW: signed FIFO head; 0 when `out_valid`=0.
- `fill`  out  $clog2(DEPTH)+1: current FIFO occupancy.
- `overflow`  out  1: sticky drop flag (only with `HB_DECIM_OVF_EN`).
- `drop_cnt`  out  16: dropped-sample count (only with `HB_DECIM_OVF_EN`).

## Operation
- Phase bit `ph` resets to 0 and toggles on every cycle with `in_valid`=1; it is unchanged when `in_valid`=0.
- Keep condition: `in_valid && (ph == phase_sel)`. Non-kept samples are discarded silently; they are not drops.
- Read: `rd = out_valid && out_ready`; the read pointer advances and `fill` decrements.
- Write: `wr = keep && (fill < DEPTH || rd)`. When the FIFO is full and a read occurs in the same cycle, the write is accepted and `fill` stays at DEPTH.
- Drop: `keep && fill == DEPTH && !rd`. The sample is discarded and the FIFO is untouched.
- Simultaneous read and write at any fill level: `fill` is unchanged and both pointers advance.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. `fill` is held in a separate counter and is never derived from pointer difference alone.
- Data passes through unmodified: no rounding or saturation, and the bit pattern is preserved.
- `out_valid` = (`fill` != 0). `y_out` = mem[rd_ptr] when `out_valid`, else 0.
- The FIFO contents array itself is not reset.
- `phase_sel` changing mid-stream takes effect on the next `in_valid` cycle. Loss or duplication of one output sample at the switch is acceptable.

## Timing
- Reset values: `ph`=0, pointers 0, `fill`=0, `out_valid`=0, `y_out`=0, `overflow`=0, `drop_cnt`=0.
- Reset mid-operation flushes the FIFO. From the cycle after `reset` is sampled high, `out_valid`=0 and `fill`=0; in-flight samples are lost and not counted as drops.
- Latency: a sample kept at edge N is visible on `y_out` with `out_valid`=1 after edge N (next cycle). There are no combinational paths from `x_in` or `in_valid` to outputs.
- `out_ready` → `out_valid`/`y_out` is combinational only through FIFO state, so a registered view is presented each cycle.
- Sustained throughput: 1 output per 2 `in_valid` cycles. With `out_ready`=1 continuously, `fill` never exceeds 1.

## Configuration
- `HB_DECIM_OVF_EN` defined:
  - `overflow` is set on the first drop and stays high until `reset`.
  - `drop_cnt` increments by 1 per drop and saturates at 16'hFFFF.
- `HB_DECIM_OVF_EN` undefined:
  - `overflow` and `drop_cnt` ports and their logic are absent.
  - Drops still occur, silently.

## Test plan
- **Reset:** assert `reset` 3 cycles with `in_valid`=1 → `out_valid`=0, `y_out`=0, `fill`=0 throughout and on the first cycle after deassertion.
- **Phase 0 decimation:**
  - Stimulus: `phase_sel`=0, `out_ready`=1, `in_valid`=1, `x_in` = 10, -20, 30, -40, 32767, -32768.
  - Required: outputs 10, 30, 32767, each appearing one cycle after its input; `fill` ≤ 1.
- **Phase 1 decimation:** same stimulus with `phase_sel`=1 → outputs -20, -40, -32768.
- **Gapped input:** `in_valid` pattern 1,0,0,1,1 with `x_in` = 1,x,x,2,3 and `phase_sel`=0 → outputs 1, 3. Phase holds across idle cycles.
- **Backpressure/overflow (DEPTH=4, `HB_DECIM_OVF_EN`):**
  - Stimulus: `out_ready`=0, keep samples 1..6.
  - Required: `fill` saturates at 4; samples 5 and 6 are dropped; `overflow`=1; `drop_cnt`=2.
  - Then raise `out_ready`: outputs are exactly 1, 2, 3, 4.
- **Full with simultaneous read/write:**
  - Stimulus: FIFO full with 1..4; on the cycle sample 5 is kept, `out_ready`=1.
  - Required: 1 is read, 5 is written, `fill` stays 4, no drop is counted; subsequent reads return 2, 3, 4, 5.
